// File: rtl/serial_tx.sv
// serial_tx: framed parallel-to-serial line driver (start bit, DATA_W data
// bits LSB first, one stop bit), each bit held CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div, div_n;
    logic [BIT_W-1:0]    bit_idx, bit_idx_n;
    logic [DATA_W-1:0]   shift, shift_n;
    logic                tx_n, busy_n, done_n;

    logic                bit_end;

    // Last clock of the current serial bit.
    assign bit_end = (div == DIV_LAST);

    // Ready comes straight from the state register so a word can be taken
    // in the done cycle.
    assign ready = (state == IDLE);

    // State, datapath and line registers; reset drops the frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_n   = state;
        div_n     = div;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;
        busy_n    = busy;
        done_n    = 1'b0;

        unique case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (valid) begin
                    shift_n = data_in;
                    div_n   = '0;
                    state_n = START;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                end
            end

            START: begin
                tx_n = 1'b0;
                if (bit_end) begin
                    div_n     = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                    tx_n      = shift[0];
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    div_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n   = shift >> 1;
                        bit_idx_n = bit_idx + BIT_W'(1);
                        tx_n      = shift_n[0];
                    end
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end

            STOP: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    div_n   = '0;
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed bench for serial_tx in two configurations
// (DATA_W=8/CLKS_PER_BIT=4 and DATA_W=5/CLKS_PER_BIT=1).
module tb_serial_tx;

    logic       clk;
    logic       rst;

    logic [7:0] data_in;
    logic       valid;
    logic       ready, tx, busy, done;

    logic [4:0] data_in_b;
    logic       valid_b;
    logic       ready_b, tx_b, busy_b, done_b;

    int checks   = 0;
    int failures = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .valid   (valid),
        .ready   (ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in_b),
        .valid   (valid_b),
        .ready   (ready_b),
        .tx      (tx_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present a word on the 8-bit instance; accept happens at the next rising edge.
    task automatic start_word(input logic [7:0] w, input bit hold_valid);
        @(negedge clk);
        data_in = w;
        valid   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_valid) valid = 1'b0;
    endtask

    // Called just after the accept edge: checks 40 frame clocks and the done cycle.
    task automatic check_frame8(input logic [7:0] w);
        logic exp_tx;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j < 4)       exp_tx = 1'b0;
            else if (j < 36) exp_tx = w[j/4 - 1];
            else             exp_tx = 1'b1;
            check("frame_tx",    tx,    exp_tx);
            check("frame_busy",  busy,  1'b1);
            check("frame_ready", ready, 1'b0);
            check("frame_done",  done,  1'b0);
        end
        @(negedge clk);
        check("end_done",  done,  1'b1);
        check("end_busy",  busy,  1'b0);
        check("end_tx",    tx,    1'b1);
        check("end_ready", ready, 1'b1);
    endtask

    initial begin
        logic [6:0] exp_b;

        rst       = 1'b1;
        valid     = 1'b1;
        data_in   = 8'hA5;
        valid_b   = 1'b0;
        data_in_b = 5'd0;

        // 1: reset held with valid high; nothing may be accepted
        repeat (3) begin
            @(negedge clk);
            check("rst_tx",    tx,    1'b1);
            check("rst_ready", ready, 1'b1);
            check("rst_busy",  busy,  1'b0);
            check("rst_done",  done,  1'b0);
        end
        valid = 1'b0;
        rst   = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_tx",   tx,   1'b1);

        // 2: single frame 8'hA5
        start_word(8'hA5, 1'b0);
        check_frame8(8'hA5);
        @(negedge clk);
        check("a5_after_done", done, 1'b0);

        // 3: back-to-back 8'h3C then 8'h81 with valid held high
        start_word(8'h3C, 1'b1);
        data_in = 8'h81;
        check_frame8(8'h3C);
        @(posedge clk);
        #1 valid = 1'b0;
        check_frame8(8'h81);

        // 4: data_in / valid activity during a frame is ignored
        start_word(8'h0F, 1'b0);
        fork
            check_frame8(8'h0F);
            begin
                repeat (10) @(posedge clk);
                #1;
                data_in = 8'hF0;
                valid   = 1'b1;
                @(posedge clk);
                #1 valid = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            check("ign_done_once", done,  1'b0);
            check("ign_idle_busy", busy,  1'b0);
            check("ign_idle_tx",   tx,    1'b1);
        end

        // 5: asynchronous reset during data bit 3 of 8'h00
        start_word(8'h00, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        check("pre_arst_tx",   tx,   1'b0);
        check("pre_arst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_tx",    tx,    1'b1);
        check("arst_busy",  busy,  1'b0);
        check("arst_ready", ready, 1'b1);
        check("arst_done",  done,  1'b0);
        repeat (2) begin
            @(negedge clk);
            check("arst_hold_done", done, 1'b0);
            check("arst_hold_tx",   tx,   1'b1);
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("no_resend_busy", busy, 1'b0);
            check("no_resend_tx",   tx,   1'b1);
            check("no_resend_done", done, 1'b0);
        end
        start_word(8'h55, 1'b0);
        check_frame8(8'h55);

        // 6: DATA_W=5, CLKS_PER_BIT=1, word 5'b10011 -> 7-clock frame
        exp_b = 7'b1100110;  // element j = tx in frame clock j (LSB first in time)
        @(negedge clk);
        check("b_idle_ready", ready_b, 1'b1);
        data_in_b = 5'b10011;
        valid_b   = 1'b1;
        @(posedge clk);
        #1 valid_b = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check("b_tx",   tx_b,   exp_b[j]);
            check("b_busy", busy_b, 1'b1);
            check("b_done", done_b, 1'b0);
        end
        @(negedge clk);
        check("b_end_done",  done_b,  1'b1);
        check("b_end_busy",  busy_b,  1'b0);
        check("b_end_tx",    tx_b,    1'b1);
        check("b_end_ready", ready_b, 1'b1);
        @(negedge clk);
        check("b_after_done", done_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out framed transmitter (UART-style: start bit, DATA_W data bits LSB first, one stop bit). Its output is the source end of a serial line. The far end samples that line with registered capture logic. A producer hands it words over a valid/ready handshake, and it shifts each word out at a fixed number of clocks per bit. It is the standard line driver for the sequential-block set.

Parameters:
DATA_W, 8, data bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
data_in  input  DATA_W  word to transmit, sampled on accept
valid  input  1  producer has a word on data_in
ready  output  1  transmitter can accept a word (high only in IDLE)
tx  output  1  serial line; idle level 1
busy  output  1  frame in progress (START/DATA/STOP)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset: rst high immediately (asynchronously) forces state=IDLE, tx=1, busy=0, done=0, ready=1, bit counter=0, clock divider=0, shift register=0. This holds mid-frame: tx returns high at once and the partial frame is abandoned. The word is not resent after reset is released.
- All state, tx, busy and done are registered. ready is decoded directly from the state register (ready = state==IDLE).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. Accept occurs when valid && ready at a rising edge. At that edge: latch data_in into the shift register, clear the divider, go to START, drive tx=0, set busy=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0] and bit index 0.
- DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right by one. Bits go out LSB first. After bit DATA_W-1 completes, go to STOP with tx=1.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy=0 and done=1 for exactly that first IDLE cycle.
- Frame timing: if accept happens at edge k, tx falls at edge k. Data bit i starts at edge k+(i+1)*CLKS_PER_BIT. Stop starts at k+(DATA_W+1)*CLKS_PER_BIT. IDLE and done occur at k+(DATA_W+2)*CLKS_PER_BIT.
- Back-to-back: accept is legal in the done cycle, since ready is already high. The minimum line idle between frames is therefore one clock of tx=1 in addition to the stop bit.
- valid is ignored while busy, and data_in changes during a frame have no effect. valid does not need to stay asserted after accept.
- Divider counts 0..CLKS_PER_BIT-1, then wraps. With CLKS_PER_BIT=1 each bit lasts exactly one clock. The bit index is clog2(DATA_W) wide (min 1).
- No X on tx at any time after rst has been asserted once.

Test Plan:
1. Reset: hold rst=1 for 3 clocks with valid=1 -> tx=1, ready=1, busy=0, done=0 throughout, and no accept.
2. Single frame, DATA_W=8, CLKS_PER_BIT=4: data_in=8'hA5 accepted at edge k -> tx runs 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each level held 4 clocks. busy is high for 40 clocks, and done pulses one cycle at edge k+40.
3. Back-to-back: valid held high with 8'h3C then 8'h81 -> second accept happens in the done cycle. tx shows exactly 4+1 high clocks between the frames, and both bit patterns are correct (LSB first).
4. Ignored input: during the 8'h0F frame, toggle data_in to 8'hF0 and pulse valid -> serial bits still match 8'h0F. ready stays low, and there is only one done pulse.
5. Mid-frame reset: assert rst asynchronously (between clock edges) at data bit 3 -> tx goes to 1 and busy to 0 without waiting for a clock edge, with no done pulse. After release, a new word 8'h55 transmits correctly.
6. CLKS_PER_BIT=1, DATA_W=5: send 5'b10011 -> 7-clock frame with tx = 0,1,1,0,0,1,1, and done at edge k+7.
